// File: rtl/handshake_pkg.sv
// Shared constants and width helpers for the handshake node family.
package handshake_pkg;

    localparam int DATA_WIDTH = 32;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// DEPTH x WIDTH register array: one write port, asynchronous read, cleared on reset.
module handshake_fifo_mem
    import handshake_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: every entry is reset so data_out reads 0 after reset, not stale beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Valid/ready FIFO; all outputs decode from registered state, so no input-to-output path.
module handshake_fifo
    import handshake_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   up_valid_in,
    output logic                   up_ready_out,
    output logic [WIDTH-1:0]       data_out,
    output logic                   dn_valid_out,
    input  logic                   dn_ready_in,
    output logic [$clog2(DEPTH):0] count_out
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push, pop;

    assign up_ready_out = (count_q != FULL_CNT);
    assign dn_valid_out = (count_q != '0);
    assign count_out    = count_q;

    assign push = up_valid_in & up_ready_out;
    assign pop  = dn_valid_out & dn_ready_in;

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments keep all state updates simultaneous at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    handshake_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed and randomized checks of handshake_fifo against a queue-based reference model.
module tb_handshake_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [WIDTH-1:0]       data_in;
    logic                   up_valid_in;
    logic                   up_ready_out;
    logic [WIDTH-1:0]       data_out;
    logic                   dn_valid_out;
    logic                   dn_ready_in;
    logic [$clog2(DEPTH):0] count_out;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] model_q [$];

    handshake_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .up_valid_in  (up_valid_in),
        .up_ready_out (up_ready_out),
        .data_out     (data_out),
        .dn_valid_out (dn_valid_out),
        .dn_ready_in  (dn_ready_in),
        .count_out    (count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare visible outputs to the model, then apply one clock edge of traffic.
    // Called at a negedge; returns at the next negedge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r,
                         input string tag, output logic accepted);
        logic do_push, do_pop;
        up_valid_in = v;
        data_in     = d;
        dn_ready_in = r;
        #1;
        check({tag, ".ready"}, 64'(up_ready_out), 64'(model_q.size() < DEPTH));
        check({tag, ".valid"}, 64'(dn_valid_out), 64'(model_q.size() > 0));
        check({tag, ".count"}, 64'(count_out), 64'(model_q.size()));
        if (model_q.size() > 0) begin
            check({tag, ".data"}, 64'(data_out), 64'(model_q[0]));
        end
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = r && (model_q.size() > 0);
        @(posedge clk);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        accepted = do_push;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, 64'(up_ready_out), 64'(1));
        check({tag, ".valid"}, 64'(dn_valid_out), 64'(0));
        check({tag, ".data"},  64'(data_out),     64'(0));
        check({tag, ".count"}, 64'(count_out),    64'(0));
    endtask

    initial begin
        logic             acc;
        logic [WIDTH-1:0] pend;
        logic             pend_v;
        int               next_val;

        rst_n       = 1'b0;
        up_valid_in = 1'b0;
        data_in     = '0;
        dn_ready_in = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill and stall: beats 0..3 accepted, beat 4 held upstream.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b0, "fill", acc);
            check("fill.acc", 64'(acc), 64'(1));
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, WIDTH'(4), 1'b0, "stall", acc);
            check("stall.acc", 64'(acc), 64'(0));
        end

        // Drain with 4 and 5 still offered; full+pop must not push that cycle.
        next_val = 4;
        for (int i = 0; i < 10; i++) begin
            cycle(next_val <= 5, WIDTH'(next_val), 1'b1, "drain", acc);
            if (i == 0) check("drain.fullpop", 64'(acc), 64'(0));
            if (acc) next_val++;
        end
        check("drain.all_in", 64'(next_val), 64'(6));
        check("drain.empty", 64'(model_q.size()), 64'(0));

        // Streaming with wrap-around: count holds at 1 after the first beat.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b1, "stream", acc);
            check("stream.acc", 64'(acc), 64'(1));
            if (i > 0) check("stream.cnt1", 64'(count_out), 64'(1));
        end
        cycle(1'b0, '0, 1'b1, "stream_tail", acc);

        // Simultaneous push/pop at count=2.
        cycle(1'b1, 32'hA0, 1'b0, "pp_fill", acc);
        cycle(1'b1, 32'hA1, 1'b0, "pp_fill", acc);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, WIDTH'(32'hB0 + i), 1'b1, "pp", acc);
            check("pp.cnt2", 64'(count_out), 64'(2));
        end

        // Reset mid-operation at count=3, between edges.
        cycle(1'b1, 32'hC0, 1'b0, "pre_rst", acc);
        check("pre_rst.cnt3", 64'(count_out), 64'(3));
        up_valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, WIDTH'(17), 1'b0, "post_rst", acc);
        check("post_rst.acc", 64'(acc), 64'(1));
        cycle(1'b0, '0, 1'b1, "post_rst17", acc);
        check("post_rst.empty", 64'(model_q.size()), 64'(0));

        // Randomized traffic; upstream holds each beat until accepted.
        pend_v = 1'b0;
        pend   = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend_v && ($urandom_range(0, 3) != 0)) begin
                pend_v = 1'b1;
                pend   = WIDTH'($urandom);
            end
            cycle(pend_v, pend, ($urandom_range(0, 2) != 0), "rand", acc);
            if (acc) pend_v = 1'b0;
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle(1'b0, '0, 1'b1, "rand_drain", acc);
        end
        check("rand.empty", 64'(dn_valid_out), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
